bit_packer: RTL and testbench



---
 rtl/bit_packer.sv | 163 ++++++++++++++++
 tb/tb_bit_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// MSB-first variable-length field packer emitting big-endian 32-bit words on valid/ready.
// Optional BIT_PACKER_BYTE_COUNT_EN adds a total_bytes counter of emitted bytes per flush.
module bit_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_enable,
  input  logic [63:0] val,
  input  logic [63:0] size_of_bit,
  input  logic        flush_bit,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_bytes,
  output logic        out_last,
  output logic        flush_done,
  output logic        size_err
`ifdef BIT_PACKER_BYTE_COUNT_EN
  ,
  output logic [31:0] total_bytes
`endif
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [127:0]  buffer_q, buffer_d;
  logic [7:0]    fill_q, fill_d;
  logic          flushDone_q, flushDone_d;
  logic          sizeErr_q, sizeErr_d;

  logic          sizeOver;
  logic [6:0]    fieldLen;
  logic [63:0]   maskedVal;
  logic [127:0]  aligned;
  logic [127:0]  bufPop;
  logic [7:0]    fillPop;
  logic [7:0]    popBits;
  logic [7:0]    filled;
  logic [7:0]    rounded;
  logic [31:0]   dataMask;
  logic          outValid;
  logic          outLast;
  logic [2:0]    outBytes;
  logic          pop;
  logic          accept;

  assign in_ready   = (state_q == RUN) && (fill_q <= 8'd64);
  assign out_valid  = outValid;
  assign out_bytes  = outBytes;
  assign out_last   = outLast;
  assign out_data   = buffer_q[127:96] & dataMask;
  assign flush_done = flushDone_q;
  assign size_err   = sizeErr_q;

  assign pop    = outValid && out_ready;
  assign accept = input_enable && in_ready;

  // Output word view; out_bytes reads 0 whenever no word is presented.
  always_comb begin
    outValid = 1'b0;
    outBytes = 3'd0;
    outLast  = 1'b0;
    dataMask = 32'hFFFF_FFFF;
    if (state_q == DRAIN) begin
      outValid = 1'b1;
      outLast  = (fill_q <= 8'd32);
      outBytes = (fill_q >= 8'd32) ? 3'd4 : {1'b0, fill_q[4:3]};
      case (outBytes)
        3'd1:    dataMask = 32'hFF00_0000;
        3'd2:    dataMask = 32'hFFFF_0000;
        3'd3:    dataMask = 32'hFFFF_FF00;
        default: dataMask = 32'hFFFF_FFFF;
      endcase
    end else if (fill_q >= 8'd32) begin
      outValid = 1'b1;
      outBytes = 3'd4;
    end
  end

  // Field is masked to its length and left-aligned in a 128-bit lane before placement.
  always_comb begin
    sizeOver  = (size_of_bit > 64'd64);
    fieldLen  = sizeOver ? 7'd64 : size_of_bit[6:0];
    maskedVal = (fieldLen == 7'd64) ? val : (val & ((64'd1 << fieldLen) - 64'd1));
    aligned   = {64'd0, maskedVal} << (8'd128 - {1'b0, fieldLen});
    popBits   = {2'b00, outBytes, 3'b000};
    fillPop   = pop ? (fill_q - popBits) : fill_q;
    bufPop    = pop ? (buffer_q << popBits) : buffer_q;
    filled    = fillPop + {1'b0, fieldLen};
    rounded   = (filled + 8'd7) & 8'hF8;
  end

  always_comb begin
    state_d     = state_q;
    buffer_d    = bufPop;
    fill_d      = fillPop;
    flushDone_d = 1'b0;
    sizeErr_d   = sizeErr_q;
    if ((state_q == DRAIN) && pop && outLast) begin
      state_d     = RUN;
      buffer_d    = '0;
      fill_d      = 8'd0;
      flushDone_d = 1'b1;
    end
    if (accept) begin
      buffer_d = bufPop | (aligned >> fillPop);
      if (sizeOver) begin
        sizeErr_d = 1'b1;
      end
      if (flush_bit) begin
        // Bits below fill are always zero, so rounding up supplies the zero padding.
        fill_d = rounded;
        if (rounded != 8'd0) begin
          state_d = DRAIN;
        end else begin
          flushDone_d = 1'b1;
        end
      end else begin
        fill_d = filled;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      buffer_q    <= '0;
      fill_q      <= 8'd0;
      flushDone_q <= 1'b0;
      sizeErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buffer_q    <= buffer_d;
      fill_q      <= fill_d;
      flushDone_q <= flushDone_d;
      sizeErr_q   <= sizeErr_d;
    end
  end

`ifdef BIT_PACKER_BYTE_COUNT_EN
  logic [31:0] totalBytes_q, totalBytes_d;

  // The final count stays visible during the flush_done cycle, then restarts from zero.
  always_comb begin
    totalBytes_d = flushDone_q ? 32'd0 : totalBytes_q;
    if (pop) begin
      totalBytes_d = totalBytes_d + {29'd0, outBytes};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      totalBytes_q <= 32'd0;
    end else begin
      totalBytes_q <= totalBytes_d;
    end
  end

  assign total_bytes = totalBytes_q;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Scoreboard bench for bit_packer: directed fields push expected words, a monitor pops on each handshake.
module tb_bit_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        input_enable;
  logic [63:0] val;
  logic [63:0] size_of_bit;
  logic        flush_bit;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        flush_done;
  logic        size_err;
`ifdef BIT_PACKER_BYTE_COUNT_EN
  logic [31:0] total_bytes;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } word_t;

  word_t expectQ[$];
  word_t monExp;
  word_t monAct;
  int    checks   = 0;
  int    failures = 0;
  logic  sawFlushDone;

  bit_packer dut (
    .clock        (clock),
    .reset        (reset),
    .input_enable (input_enable),
    .val          (val),
    .size_of_bit  (size_of_bit),
    .flush_bit    (flush_bit),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bytes    (out_bytes),
    .out_last     (out_last),
    .flush_done   (flush_done),
    .size_err     (size_err)
`ifdef BIT_PACKER_BYTE_COUNT_EN
    ,
    .total_bytes  (total_bytes)
`endif
  );

  always #5 clock = ~clock;

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      monAct = {out_data, out_bytes, out_last};
      checks++;
      if (expectQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_word: got data=%08h bytes=%0d last=%0b, none expected",
                 out_data, out_bytes, out_last);
      end else begin
        monExp = expectQ.pop_front();
        if (monAct !== monExp) begin
          failures++;
          $display("[TB] FAIL word: got data=%08h bytes=%0d last=%0b expected data=%08h bytes=%0d last=%0b",
                   monAct.data, monAct.bytes, monAct.last, monExp.data, monExp.bytes, monExp.last);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectWord(input logic [31:0] data, input logic [2:0] bytes, input logic last);
    word_t w;
    w.data  = data;
    w.bytes = bytes;
    w.last  = last;
    expectQ.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Presents one field, holds it until in_ready, returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [63:0] v, input logic [63:0] s, input logic f);
    int waitCycles;
    waitCycles   = 0;
    val          = v;
    size_of_bit  = s;
    flush_bit    = f;
    input_enable = 1'b1;
    while (!in_ready && waitCycles < 200) begin
      tick(1);
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waitCycles);
    end else begin
      tick(1);
    end
    input_enable = 1'b0;
    flush_bit    = 1'b0;
    val          = 64'd0;
    size_of_bit  = 64'd0;
  endtask

  task automatic waitDrained();
    int waitCycles;
    waitCycles = 0;
    while (expectQ.size() != 0 && waitCycles < 200) begin
      tick(1);
      waitCycles++;
    end
    checkOutput("queue_empty", 64'(expectQ.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset        = 1'b1;
    input_enable = 1'b0;
    val          = 64'd0;
    size_of_bit  = 64'd0;
    flush_bit    = 1'b0;
    out_ready    = 1'b1;
    tick(3);
    checkOutput("rst_out_valid",  64'(out_valid),  64'd0);
    checkOutput("rst_out_data",   64'(out_data),   64'd0);
    checkOutput("rst_out_bytes",  64'(out_bytes),  64'd0);
    checkOutput("rst_out_last",   64'(out_last),   64'd0);
    checkOutput("rst_flush_done", 64'(flush_done), 64'd0);
    checkOutput("rst_size_err",   64'(size_err),   64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Four byte fields form one full word.
    $display("[TB] test: four byte fields");
    expectWord(32'h0405_0607, 3'd4, 1'b0);
    for (int i = 4; i < 8; i++) begin
      applyStimulus(64'(i), 64'd8, 1'b0);
      checkOutput("t1_in_ready", 64'(in_ready), 64'd1);
    end
    waitDrained();
    tick(1);
    checkOutput("t1_idle_valid", 64'(out_valid), 64'd0);

    // Short flush: 3 bits padded to a single byte.
    $display("[TB] test: 3-bit flush");
    expectWord(32'hA000_0000, 3'd1, 1'b1);
    applyStimulus(64'h5, 64'd3, 1'b1);
    checkOutput("t2_in_ready_drain", 64'(in_ready),   64'd0);
    checkOutput("t2_flush_done_pre", 64'(flush_done), 64'd0);
    tick(1);
    checkOutput("t2_flush_done",     64'(flush_done), 64'd1);
    checkOutput("t2_valid_after",    64'(out_valid),  64'd0);
    checkOutput("t2_in_ready_after", 64'(in_ready),   64'd1);
    tick(1);
    checkOutput("t2_flush_done_end", 64'(flush_done), 64'd0);
    waitDrained();

    // Multi-word drain: 36 bits padded to 40.
    $display("[TB] test: 36-bit flush");
    expectWord(32'hFEDC_BA98, 3'd4, 1'b0);
    expectWord(32'h7000_0000, 3'd1, 1'b1);
    applyStimulus(64'hF_EDCB_A987, 64'd36, 1'b1);
    waitDrained();
    tick(1);
    checkOutput("t2b_in_ready", 64'(in_ready), 64'd1);

    // Backpressure with a full buffer.
    $display("[TB] test: backpressure to 128 bits");
    out_ready = 1'b0;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b0);
    checkOutput("t3_in_ready_64", 64'(in_ready), 64'd1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b0);
    checkOutput("t3_in_ready_128", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      expectWord(32'hFFFF_FFFF, 3'd4, 1'b0);
    end
    tick(3);
    checkOutput("t3_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("t3_hold_data",  64'(out_data),  64'hFFFF_FFFF);
    out_ready = 1'b1;
    tick(1);
    checkOutput("t3_in_ready_96", 64'(in_ready), 64'd0);
    tick(1);
    checkOutput("t3_in_ready_64b", 64'(in_ready), 64'd1);
    waitDrained();

    // Oversized length clamps to 64 bits and sets the sticky error.
    $display("[TB] test: oversized field");
    expectWord(32'h0123_4567, 3'd4, 1'b0);
    expectWord(32'h89AB_CDEF, 3'd4, 1'b0);
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'd70, 1'b0);
    checkOutput("t4_size_err", 64'(size_err), 64'd1);
    waitDrained();
    tick(5);
    checkOutput("t4_size_err_sticky", 64'(size_err), 64'd1);

    // Reset in the middle of a drain.
    $display("[TB] test: reset during drain");
    out_ready = 1'b0;
    applyStimulus(64'hAA_BBCC_DDEE, 64'd40, 1'b1);
    checkOutput("t5_drain_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_drain_data",  64'(out_data),  64'hAABB_CCDD);
    checkOutput("t5_drain_bytes", 64'(out_bytes), 64'd4);
    checkOutput("t5_drain_last",  64'(out_last),  64'd0);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_valid",    64'(out_valid), 64'd0);
    checkOutput("t5_rst_size_err", 64'(size_err),  64'd0);
    tick(1);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
    sawFlushDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (flush_done || out_valid) sawFlushDone = 1'b1;
    end
    checkOutput("t5_no_flush_done", 64'(sawFlushDone), 64'd0);

    // Zero-length flush on an empty buffer.
    $display("[TB] test: empty flush");
    applyStimulus(64'h0, 64'd0, 1'b1);
    checkOutput("t6_flush_done", 64'(flush_done), 64'd1);
    checkOutput("t6_valid",      64'(out_valid),  64'd0);
    tick(1);
    checkOutput("t6_flush_done_end", 64'(flush_done), 64'd0);
    checkOutput("t6_in_ready",       64'(in_ready),   64'd1);

    waitDrained();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
